// File: rtl/fb_sram_arbiter_pkg.sv
// Shared widths and slot encoding for the frame-buffer SRAM arbiter.
package fb_sram_arbiter_pkg;

  localparam int unsigned FB_ADDR_W_DEF  = 18;
  localparam int unsigned FB_DATA_W_DEF  = 16;
  localparam int unsigned WBUF_DEPTH_DEF = 4;
  localparam int unsigned STALL_CNT_W    = 16;

  // One SRAM slot per cycle; enum order mirrors the grant priority.
  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_DISP_RD = 2'd1,
    SLOT_GPU_RD  = 2'd2,
    SLOT_WR      = 2'd3
  } slot_e;

endpackage

// File: rtl/fb_wbuf_fifo.sv
// Posted-write buffer: synchronous FIFO of {addr, data} entries, power-of-two depth.
module fb_wbuf_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_sram_arbiter.sv
// Frame-buffer SRAM port arbiter: display reads > GPU read > posted-write drain.
// Optional stall-cycle counter enabled by defining FB_ARB_PERF_EN.
module fb_sram_arbiter
  import fb_sram_arbiter_pkg::*;
#(
  parameter int unsigned FB_ADDR_W  = FB_ADDR_W_DEF,
  parameter int unsigned FB_DATA_W  = FB_DATA_W_DEF,
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 I_DISP_REQ,
  input  logic [FB_ADDR_W-1:0] I_DISP_ADDR,
  output logic [FB_DATA_W-1:0] O_DISP_RDATA,
  output logic                 O_DISP_RVALID,
  input  logic                 I_GPU_REQ,
  input  logic                 I_GPU_WE,
  input  logic [FB_ADDR_W-1:0] I_GPU_ADDR,
  input  logic [FB_DATA_W-1:0] I_GPU_WDATA,
  output logic                 O_GPU_READY,
  output logic [FB_DATA_W-1:0] O_GPU_RDATA,
  output logic                 O_GPU_RVALID,
  output logic                 O_GPUStallSignal,
  output logic [FB_ADDR_W-1:0] O_SRAM_ADDR,
  output logic [FB_DATA_W-1:0] O_SRAM_DQ,
  output logic                 O_SRAM_DQ_OE,
  output logic                 O_SRAM_WE_N,
  output logic                 O_SRAM_OE_N,
  input  logic [FB_DATA_W-1:0] I_SRAM_DQ
`ifdef FB_ARB_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] O_GPU_STALL_CYCLES
`endif
);

  localparam int unsigned ENTRY_W = FB_ADDR_W + FB_DATA_W;

  logic               wbuf_full;
  logic               wbuf_empty;
  logic               wbuf_push;
  logic               wbuf_pop;
  logic [ENTRY_W-1:0] wbuf_head;
  logic               rd_inflight;
  logic               gpu_rd_acc;
  logic               disp_pend;
  logic               gpu_pend;
  slot_e              slot_c;

  fb_wbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .I_CLK     (I_CLK),
    .I_RST_N   (I_RST_N),
    .push      (wbuf_push),
    .push_data ({I_GPU_ADDR, I_GPU_WDATA}),
    .pop       (wbuf_pop),
    .full      (wbuf_full),
    .empty     (wbuf_empty),
    .head      (wbuf_head)
  );

  // Reads wait for an empty buffer, which is what keeps them coherent with posted writes.
  always_comb begin
    O_GPU_READY = 1'b0;
    if (I_GPU_WE) O_GPU_READY = !wbuf_full;
    else          O_GPU_READY = wbuf_empty && !rd_inflight && !I_DISP_REQ;
  end

  assign O_GPUStallSignal = I_GPU_REQ && !O_GPU_READY;
  assign wbuf_push        = I_GPU_REQ && I_GPU_WE && O_GPU_READY;
  assign gpu_rd_acc       = I_GPU_REQ && !I_GPU_WE && O_GPU_READY;

  // Slot grant for this cycle.
  always_comb begin
    slot_c = SLOT_IDLE;
    if (I_DISP_REQ)       slot_c = SLOT_DISP_RD;
    else if (gpu_rd_acc)  slot_c = SLOT_GPU_RD;
    else if (!wbuf_empty) slot_c = SLOT_WR;
  end

  assign wbuf_pop = (slot_c == SLOT_WR);

  // SRAM pin registers; the address and DQ hold through idle slots.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_SRAM_ADDR  <= '0;
      O_SRAM_DQ    <= '0;
      O_SRAM_DQ_OE <= 1'b0;
      O_SRAM_WE_N  <= 1'b1;
      O_SRAM_OE_N  <= 1'b1;
      disp_pend    <= 1'b0;
      gpu_pend     <= 1'b0;
    end else begin
      O_SRAM_DQ_OE <= 1'b0;
      O_SRAM_WE_N  <= 1'b1;
      O_SRAM_OE_N  <= 1'b1;
      disp_pend    <= 1'b0;
      gpu_pend     <= 1'b0;
      unique case (slot_c)
        SLOT_DISP_RD: begin
          O_SRAM_ADDR <= I_DISP_ADDR;
          O_SRAM_OE_N <= 1'b0;
          disp_pend   <= 1'b1;
        end
        SLOT_GPU_RD: begin
          O_SRAM_ADDR <= I_GPU_ADDR;
          O_SRAM_OE_N <= 1'b0;
          gpu_pend    <= 1'b1;
        end
        SLOT_WR: begin
          O_SRAM_ADDR  <= wbuf_head[ENTRY_W-1 -: FB_ADDR_W];
          O_SRAM_DQ    <= wbuf_head[FB_DATA_W-1:0];
          O_SRAM_DQ_OE <= 1'b1;
          O_SRAM_WE_N  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Read return: sample DQ at the end of the pin cycle.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_DISP_RDATA  <= '0;
      O_DISP_RVALID <= 1'b0;
      O_GPU_RDATA   <= '0;
      O_GPU_RVALID  <= 1'b0;
      rd_inflight   <= 1'b0;
    end else begin
      O_DISP_RVALID <= disp_pend;
      O_GPU_RVALID  <= gpu_pend;
      if (disp_pend) O_DISP_RDATA <= I_SRAM_DQ;
      if (gpu_pend)  O_GPU_RDATA  <= I_SRAM_DQ;
      if (gpu_rd_acc)        rd_inflight <= 1'b1;
      else if (O_GPU_RVALID) rd_inflight <= 1'b0;
    end
  end

`ifdef FB_ARB_PERF_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      stall_cnt <= '0;
    end else if (O_GPUStallSignal && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign O_GPU_STALL_CYCLES = stall_cnt;
`endif

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed scoreboard bench for fb_sram_arbiter with a behavioural SRAM model.
module tb_fb_sram_arbiter;

  logic        I_CLK;
  logic        I_RST_N;
  logic        I_DISP_REQ;
  logic [17:0] I_DISP_ADDR;
  logic [15:0] O_DISP_RDATA;
  logic        O_DISP_RVALID;
  logic        I_GPU_REQ;
  logic        I_GPU_WE;
  logic [17:0] I_GPU_ADDR;
  logic [15:0] I_GPU_WDATA;
  logic        O_GPU_READY;
  logic [15:0] O_GPU_RDATA;
  logic        O_GPU_RVALID;
  logic        O_GPUStallSignal;
  logic [17:0] O_SRAM_ADDR;
  logic [15:0] O_SRAM_DQ;
  logic        O_SRAM_DQ_OE;
  logic        O_SRAM_WE_N;
  logic        O_SRAM_OE_N;
  logic [15:0] I_SRAM_DQ;
`ifdef FB_ARB_PERF_EN
  logic [15:0] O_GPU_STALL_CYCLES;
`endif

  fb_sram_arbiter dut (
    .I_CLK            (I_CLK),
    .I_RST_N          (I_RST_N),
    .I_DISP_REQ       (I_DISP_REQ),
    .I_DISP_ADDR      (I_DISP_ADDR),
    .O_DISP_RDATA     (O_DISP_RDATA),
    .O_DISP_RVALID    (O_DISP_RVALID),
    .I_GPU_REQ        (I_GPU_REQ),
    .I_GPU_WE         (I_GPU_WE),
    .I_GPU_ADDR       (I_GPU_ADDR),
    .I_GPU_WDATA      (I_GPU_WDATA),
    .O_GPU_READY      (O_GPU_READY),
    .O_GPU_RDATA      (O_GPU_RDATA),
    .O_GPU_RVALID     (O_GPU_RVALID),
    .O_GPUStallSignal (O_GPUStallSignal),
    .O_SRAM_ADDR      (O_SRAM_ADDR),
    .O_SRAM_DQ        (O_SRAM_DQ),
    .O_SRAM_DQ_OE     (O_SRAM_DQ_OE),
    .O_SRAM_WE_N      (O_SRAM_WE_N),
    .O_SRAM_OE_N      (O_SRAM_OE_N),
    .I_SRAM_DQ        (I_SRAM_DQ)
`ifdef FB_ARB_PERF_EN
    ,
    .O_GPU_STALL_CYCLES (O_GPU_STALL_CYCLES)
`endif
  );

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          cyc;   // expected cycle, -1 = not yet known
  } exp_t;

  exp_t q_disp[$];
  exp_t q_gpu[$];
  exp_t q_wr[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   post_evt = 0;

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [9:0] a);
    return 16'h1234 + {6'd0, a} * 16'd7;
  endfunction

  // SRAM model: unwritten words read back init_val(addr); contents forget writes on reset.
  logic [15:0]   sram_mem [1024];
  logic [1023:0] written;
  always @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      written <= '0;
    end else if (!O_SRAM_WE_N && O_SRAM_DQ_OE) begin
      sram_mem[O_SRAM_ADDR[9:0]] <= O_SRAM_DQ;
      written[O_SRAM_ADDR[9:0]]  <= 1'b1;
    end
  end
  assign I_SRAM_DQ = !O_SRAM_OE_N ? (written[O_SRAM_ADDR[9:0]] ? sram_mem[O_SRAM_ADDR[9:0]]
                                                               : init_val(O_SRAM_ADDR[9:0]))
                                  : 16'h0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every read return and write pulse.
  always @(negedge I_CLK) begin
    exp_t e;
    if (I_RST_N) begin
      if (O_DISP_RVALID) begin
        if (q_disp.size() == 0) begin post_evt++; chk("disp_unexpected", 64'(O_DISP_RVALID), 64'(0)); end
        else begin
          e = q_disp.pop_front();
          chk("disp_data", 64'(O_DISP_RDATA), 64'(e.data));
          chk("disp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (O_GPU_RVALID) begin
        if (q_gpu.size() == 0) begin post_evt++; chk("gpu_unexpected", 64'(O_GPU_RVALID), 64'(0)); end
        else begin
          e = q_gpu.pop_front();
          chk("gpu_data", 64'(O_GPU_RDATA), 64'(e.data));
          chk("gpu_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (!O_SRAM_WE_N) begin
        chk("wr_pins", 64'({O_SRAM_OE_N, O_SRAM_DQ_OE}), 64'(2'b11));
        if (q_wr.size() == 0) begin post_evt++; chk("wr_unexpected", 64'(O_SRAM_WE_N), 64'(1)); end
        else begin
          e = q_wr.pop_front();
          chk("wr_addr", 64'(O_SRAM_ADDR), 64'(e.addr));
          chk("wr_data", 64'(O_SRAM_DQ), 64'(e.data));
          if (e.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (!O_SRAM_OE_N) chk("rd_pins", 64'({O_SRAM_WE_N, O_SRAM_DQ_OE}), 64'(2'b10));
    end
  end

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic set_disp(input logic en, input logic [17:0] a);
    I_DISP_REQ  = en;
    I_DISP_ADDR = a;
    if (en) q_disp.push_back('{addr: a, data: init_val(a[9:0]), cyc: cyc + 2});
  endtask

  task automatic set_gpu(input logic req, input logic we, input logic [17:0] a, input logic [15:0] d);
    I_GPU_REQ   = req;
    I_GPU_WE    = we;
    I_GPU_ADDR  = a;
    I_GPU_WDATA = d;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (q_disp.size() + q_gpu.size() + q_wr.size() == 0) break;
      step();
    end
    chk("drain_pending", 64'(q_disp.size() + q_gpu.size() + q_wr.size()), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge I_CLK);
    chk(tag, 64'({O_SRAM_ADDR, O_SRAM_DQ, O_SRAM_DQ_OE, O_SRAM_WE_N, O_SRAM_OE_N}), 64'({18'd0, 16'd0, 3'b011}));
    chk(tag, 64'({O_DISP_RDATA, O_DISP_RVALID, O_GPU_RDATA, O_GPU_RVALID}), 64'(0));
    chk(tag, 64'({O_GPU_READY, O_GPUStallSignal}), 64'(2'b10));
  endtask

  task automatic do_reset();
    I_RST_N = 1'b0;
    q_disp.delete();
    q_gpu.delete();
    q_wr.delete();
    set_disp(1'b0, '0);
    set_gpu(1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_rdy;
    int   c0;
    int   acc;
    int   d_cyc;

    I_RST_N = 1'b0;
    set_disp(1'b0, '0);
    set_gpu(1'b0, 1'b1, '0, '0);
    repeat (3) @(posedge I_CLK);
    chk_reset_outputs("reset_values");
`ifdef FB_ARB_PERF_EN
    chk("perf_reset", 64'(O_GPU_STALL_CYCLES), 64'(0));
`endif
    I_RST_N = 1'b1;
    step();

    // Display stream 0..9 back to back.
    for (int i = 0; i < 10; i++) begin
      set_disp(1'b1, 18'(i));
      step();
    end
    set_disp(1'b0, '0);
    wait_drain();

    // GPU write burst with display idle.
    for (int i = 0; i < 6; i++) begin
      set_gpu(1'b1, 1'b1, 18'(100 + i), 16'h0F00);
      @(negedge I_CLK);
      chk("burst_ready", 64'({O_GPU_READY, O_GPUStallSignal}), 64'(2'b10));
      q_wr.push_back('{addr: 18'(100 + i), data: 16'h0F00, cyc: cyc + 2});
      step();
    end
    set_gpu(1'b0, 1'b1, '0, '0);
    wait_drain();

    // Buffer fills while the display owns every slot.
    for (int k = 0; k < 8; k++) begin
      set_disp(1'b1, 18'(20 + k));
      if (k < 6) set_gpu(1'b1, 1'b1, 18'(300 + k), 16'h3000 + 16'(k));
      else       set_gpu(1'b0, 1'b1, '0, '0);
      @(negedge I_CLK);
      if (k < 6) begin
        exp_rdy = (k < 4);
        chk("full_ready", 64'(O_GPU_READY), 64'(exp_rdy));
        chk("full_stall", 64'(O_GPUStallSignal), 64'(!exp_rdy));
        if (exp_rdy) q_wr.push_back('{addr: 18'(300 + k), data: 16'h3000 + 16'(k), cyc: -1});
      end
      step();
    end
    set_disp(1'b0, '0);
    d_cyc = cyc;
    for (int i = 0; i < q_wr.size(); i++) q_wr[i].cyc = d_cyc + 1 + i;
    chk("full_accepted", 64'(q_wr.size()), 64'(4));
    wait_drain();

    // Read-after-write coherence, then single-outstanding read rate.
    set_gpu(1'b1, 1'b1, 18'd200, 16'hABCD);
    @(negedge I_CLK);
    chk("coh_wr_ready", 64'(O_GPU_READY), 64'(1));
    c0 = cyc;
    q_wr.push_back('{addr: 18'd200, data: 16'hABCD, cyc: c0 + 2});
    step();
    set_gpu(1'b1, 1'b0, 18'd200, '0);
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge I_CLK);
      if (i == 0) chk("coh_stall_first", 64'(O_GPUStallSignal), 64'(1));
      if (O_GPU_READY) begin
        acc = cyc;
        break;
      end
      step();
    end
    chk("coh_accept_cycle", 64'(acc), 64'(c0 + 2));
    if (acc >= 0) q_gpu.push_back('{addr: 18'd200, data: 16'hABCD, cyc: acc + 2});
    step();
    set_gpu(1'b1, 1'b0, 18'd5, '0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge I_CLK);
      chk("rd_rate_ready", 64'(O_GPU_READY), 64'(j == 3));
      if (j == 3) q_gpu.push_back('{addr: 18'd5, data: init_val(10'd5), cyc: cyc + 2});
      step();
    end
    set_gpu(1'b0, 1'b1, '0, '0);
    wait_drain();

    // Reset with three writes stuck behind display traffic.
    for (int k = 0; k < 3; k++) begin
      set_disp(1'b1, 18'(40 + k));
      set_gpu(1'b1, 1'b1, 18'(400 + k), 16'h4000 + 16'(k));
      @(negedge I_CLK);
      chk("rstA_ready", 64'(O_GPU_READY), 64'(1));
      step();
    end
    set_gpu(1'b0, 1'b1, '0, '0);
    set_disp(1'b1, 18'd43);
    do_reset();
    chk_reset_outputs("rstA_values");
    step();
    I_RST_N  = 1'b1;
    post_evt = 0;
    repeat (10) step();
    chk("rstA_no_events", 64'(post_evt), 64'(0));

    // Reset with a GPU read in flight.
    set_gpu(1'b1, 1'b0, 18'd7, '0);
    @(negedge I_CLK);
    chk("rstB_accept", 64'(O_GPU_READY), 64'(1));
    step();
    do_reset();
    chk_reset_outputs("rstB_values");
    step();
    I_RST_N  = 1'b1;
    post_evt = 0;
    repeat (10) step();
    chk("rstB_no_events", 64'(post_evt), 64'(0));

`ifdef FB_ARB_PERF_EN
    // Stall counter: 20 stalled cycles, then saturation.
    chk("perf_after_reset", 64'(O_GPU_STALL_CYCLES), 64'(0));
    for (int k = 0; k < 4; k++) begin
      set_disp(1'b1, 18'(60 + k));
      set_gpu(1'b1, 1'b1, 18'(500 + k), 16'h5000 + 16'(k));
      q_wr.push_back('{addr: 18'(500 + k), data: 16'h5000 + 16'(k), cyc: -1});
      step();
    end
    for (int k = 0; k < 20; k++) begin
      set_disp(1'b1, 18'(70 + k));
      set_gpu(1'b1, 1'b1, 18'd600, 16'h6000);
      step();
    end
    set_disp(1'b1, 18'd90);
    set_gpu(1'b0, 1'b1, '0, '0);
    @(negedge I_CLK);
    chk("perf_count20", 64'(O_GPU_STALL_CYCLES), 64'(20));
    force dut.stall_cnt = 16'hFFFD;
    step();
    release dut.stall_cnt;
    for (int k = 0; k < 5; k++) begin
      set_disp(1'b1, 18'(91 + k));
      set_gpu(1'b1, 1'b1, 18'd600, 16'h6000);
      step();
    end
    set_gpu(1'b0, 1'b1, '0, '0);
    set_disp(1'b0, '0);
    @(negedge I_CLK);
    chk("perf_saturate", 64'(O_GPU_STALL_CYCLES), 64'(16'hFFFF));
    step();
    wait_drain();
`endif

    repeat (4) step();
    chk("final_queues", 64'(q_disp.size() + q_gpu.size() + q_wr.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
